// File: rtl/vram_rop.sv
// Single-clock video RAM: free-running render read port plus a command-driven
// user port with auto-increment pointer, raster-op read-modify-write and block fill.
module vram_rop #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 24576
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] render_addr,
  output logic [DATA_W-1:0] render_data,
  input  logic              user_cmd_valid,
  output logic              user_cmd_ready,
  input  logic [1:0]        user_cmd_op,
  input  logic [1:0]        user_cmd_rop,
  input  logic [DATA_W-1:0] user_cmd_data,
  input  logic [ADDR_W-1:0] user_cmd_addr,
  output logic [DATA_W-1:0] user_rdata,
  output logic              user_rvalid,
  output logic [ADDR_W-1:0] user_ptr,
  output logic              busy
);

  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  localparam logic [1:0] OP_SETADDR = 2'd0;
  localparam logic [1:0] OP_WRITE   = 2'd1;
  localparam logic [1:0] OP_READ    = 2'd2;
  localparam logic [1:0] OP_FILL    = 2'd3;

  localparam logic [1:0] ROP_COPY = 2'd0;
  localparam logic [1:0] ROP_AND  = 2'd1;
  localparam logic [1:0] ROP_OR   = 2'd2;
  localparam logic [1:0] ROP_XOR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RMW,
    ST_FILL
  } state_t;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_next_inc;
  logic [ADDR_W-1:0] fill_cnt;
  logic [DATA_W-1:0] fill_data;
  logic [DATA_W-1:0] rmw_old;
  logic [DATA_W-1:0] rmw_data;
  logic [1:0]        rmw_rop;
  logic [DATA_W-1:0] rmw_result;

  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              ptr_inc;
  logic              ptr_load;
  logic              rd_en;
  logic              rmw_latch;
  logic              fill_start;
  logic              cnt_dec;

  assign ptr_next_inc   = (ptr == LAST) ? '0 : ptr + ONE;
  assign user_cmd_ready = (state == ST_IDLE);
  assign busy           = (state != ST_IDLE);
  assign user_ptr       = ptr;

  always_comb begin
    rmw_result = rmw_data;
    case (rmw_rop)
      ROP_AND: rmw_result = rmw_old & rmw_data;
      ROP_OR:  rmw_result = rmw_old | rmw_data;
      ROP_XOR: rmw_result = rmw_old ^ rmw_data;
      default: rmw_result = rmw_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Gating acceptance with rst_n keeps a command held during reset from writing memory.
  always_comb begin
    state_n    = state;
    mem_we     = 1'b0;
    mem_wdata  = user_cmd_data;
    ptr_inc    = 1'b0;
    ptr_load   = 1'b0;
    rd_en      = 1'b0;
    rmw_latch  = 1'b0;
    fill_start = 1'b0;
    cnt_dec    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (user_cmd_valid && rst_n) begin
          case (user_cmd_op)
            OP_SETADDR: ptr_load = 1'b1;
            OP_WRITE: begin
              if (user_cmd_rop == ROP_COPY) begin
                mem_we  = 1'b1;
                ptr_inc = 1'b1;
              end else begin
                rmw_latch = 1'b1;
                state_n   = ST_RMW;
              end
            end
            OP_READ: begin
              rd_en   = 1'b1;
              ptr_inc = 1'b1;
            end
            OP_FILL: begin
              if (user_cmd_addr != '0) begin
                mem_we  = 1'b1;
                ptr_inc = 1'b1;
                if (user_cmd_addr > ONE) begin
                  fill_start = 1'b1;
                  state_n    = ST_FILL;
                end
              end
            end
            default: ;
          endcase
        end
      end
      ST_RMW: begin
        mem_we    = 1'b1;
        mem_wdata = rmw_result;
        ptr_inc   = 1'b1;
        state_n   = ST_IDLE;
      end
      ST_FILL: begin
        mem_we    = 1'b1;
        mem_wdata = fill_data;
        ptr_inc   = 1'b1;
        cnt_dec   = 1'b1;
        if (fill_cnt == ONE) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr] <= mem_wdata;
  end

  // Out-of-range render addresses read as zero instead of aliasing into the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      render_data <= '0;
    end else if ({1'b0, render_addr} < DEPTH_W) begin
      render_data <= mem[render_addr];
    end else begin
      render_data <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      user_rdata  <= '0;
      user_rvalid <= 1'b0;
      rmw_old     <= '0;
      rmw_data    <= '0;
      rmw_rop     <= ROP_COPY;
      fill_data   <= '0;
      fill_cnt    <= '0;
    end else begin
      user_rvalid <= rd_en;
      if (rd_en) user_rdata <= mem[ptr];
      if (rmw_latch) begin
        rmw_old  <= mem[ptr];
        rmw_data <= user_cmd_data;
        rmw_rop  <= user_cmd_rop;
      end
      if (fill_start) begin
        fill_data <= user_cmd_data;
        fill_cnt  <= user_cmd_addr - ONE;
      end else if (cnt_dec) begin
        fill_cnt <= fill_cnt - ONE;
      end
      if (ptr_load) begin
        ptr <= ({1'b0, user_cmd_addr} < DEPTH_W) ? user_cmd_addr : '0;
      end else if (ptr_inc) begin
        ptr <= ptr_next_inc;
      end
    end
  end

endmodule
